// File: rtl/output_ser_pkg.sv
// Shared sizes and FSM state encodings for the output matrix serializer.
package output_ser_pkg;

    localparam int ELEM_W   = 16;
    localparam int DIM      = 4;
    localparam int NUM_ELEM = DIM * DIM;
    localparam int BEAT_W   = 4;
    localparam int MAT_W    = ELEM_W * NUM_ELEM;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/ser_elem_select.sv
// Picks one element of the captured matrix for a given beat.
// Stream order is row-major, or column-major when OUTPUT_SER_COL_MAJOR_EN is defined.
module ser_elem_select #(
    parameter int ELEM_W = 16,
    parameter int DIM    = 4
) (
    input  logic [ELEM_W*DIM*DIM-1:0]   buffer,
    input  logic [$clog2(DIM*DIM)-1:0]  beat,
    output logic [ELEM_W-1:0]           elem
);

    localparam int BW = $clog2(DIM * DIM);

    logic [BW-1:0] idx;

    always_comb begin
`ifdef OUTPUT_SER_COL_MAJOR_EN
        // beat k walks down a column: row k%DIM, col k/DIM
        idx = BW'((int'(beat) % DIM) * DIM + int'(beat) / DIM);
`else
        idx = beat;
`endif
    end

    assign elem = buffer[idx*ELEM_W +: ELEM_W];

endmodule

// File: rtl/output_serializer.sv
// Reads the 4x4 output matrix register once per start and streams its 16 elements
// over valid/ready. Column-major order is selected by OUTPUT_SER_COL_MAJOR_EN.
module output_serializer #(
    parameter int ELEM_W = 16,
    parameter int DIM    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        mat_read,
    input  logic [ELEM_W*DIM*DIM-1:0]   mat_data,
    output logic [ELEM_W-1:0]           out_data,
    output logic [$clog2(DIM*DIM)-1:0]  out_index,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    import output_ser_pkg::*;

    localparam int BW = $clog2(DIM * DIM);
    localparam logic [BW-1:0] LAST_BEAT = BW'(DIM * DIM - 1);

    logic [2:0]                 state;
    logic [BW-1:0]              beat;
    logic [ELEM_W*DIM*DIM-1:0]  buffer;
    logic [ELEM_W-1:0]          elem;

    ser_elem_select #(
        .ELEM_W (ELEM_W),
        .DIM    (DIM)
    ) u_sel (
        .buffer (buffer),
        .beat   (beat),
        .elem   (elem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            beat   <= '0;
            buffer <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_REQ;
                S_REQ:  state <= S_CAP;
                S_CAP: begin
                    // the register drives mat_data throughout REQ/CAP; sample once here
                    buffer <= mat_data;
                    beat   <= '0;
                    state  <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (beat == LAST_BEAT) state <= S_DONE;
                        else                   beat  <= beat + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // outputs are gated by state so everything reads zero outside SEND
    assign mat_read  = (state == S_REQ) || (state == S_CAP);
    assign out_valid = (state == S_SEND);
    assign out_data  = out_valid ? elem : '0;
    assign out_index = out_valid ? beat : '0;
    assign out_last  = out_valid && (beat == LAST_BEAT);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_output_serializer.sv
// Directed self-checking bench for output_serializer (honours OUTPUT_SER_COL_MAJOR_EN).
module tb_output_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         mat_read;
    logic [255:0] mat_data;
    logic [15:0]  out_data;
    logic [3:0]   out_index;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    output_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mat_read  (mat_read),
        .mat_data  (mat_data),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] build(input logic [15:0] base);
        logic [255:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i*16 +: 16] = base + 16'(i);
        return m;
    endfunction

    // element value expected on beat k for a matrix whose element i is base+i
    function automatic logic [15:0] exp_elem(input logic [15:0] base, input int k);
        int idx;
`ifdef OUTPUT_SER_COL_MAJOR_EN
        idx = (k % 4) * 4 + k / 4;
`else
        idx = k;
`endif
        return base + 16'(idx);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".mat_read"},  {31'd0, mat_read},  32'd0);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".out_last"},  {31'd0, out_last},  32'd0);
        check({tag, ".out_data"},  {16'd0, out_data},  32'd0);
        check({tag, ".out_index"}, {28'd0, out_index}, 32'd0);
        check({tag, ".busy"},      {31'd0, busy},      32'd0);
        check({tag, ".done"},      {31'd0, done},      32'd0);
    endtask

    task automatic check_beat(input string tag, input logic [15:0] base, input int k);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".data"},  {16'd0, out_data},  {16'd0, exp_elem(base, k)});
        check({tag, ".index"}, {28'd0, out_index}, 32'(k));
        check({tag, ".last"},  {31'd0, out_last},  {31'd0, (k == 15)});
        check({tag, ".busy"},  {31'd0, busy},      32'd1);
        check({tag, ".read"},  {31'd0, mat_read},  32'd0);
        check({tag, ".done"},  {31'd0, done},      32'd0);
    endtask

    // Full start-to-idle operation. Stalls stall_len cycles before accepting each
    // beat set in stall_mask; optionally pokes start at one beat / in DONE, and
    // clobbers mat_data once streaming has begun.
    task automatic stream(input string tag, input logic [15:0] base,
                          input logic [15:0] stall_mask, input int stall_len,
                          input int poke_beat, input bit poke_done, input bit clobber);
        mat_data  = build(base);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".req_read"},  {31'd0, mat_read},  32'd1);
        check({tag, ".req_busy"},  {31'd0, busy},      32'd1);
        check({tag, ".req_valid"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, ".cap_read"},  {31'd0, mat_read},  32'd1);
        check({tag, ".cap_valid"}, {31'd0, out_valid}, 32'd0);
        tick();
        for (int k = 0; k < 16; k++) begin
            if (clobber && k == 1) mat_data = {16{16'hFFFF}};
            if (stall_mask[k]) begin
                for (int s = 0; s < stall_len; s++) begin
                    out_ready = 1'b0;
                    check_beat({tag, ".stall"}, base, k);
                    tick();
                end
            end
            out_ready = 1'b1;
            start = (k == poke_beat);
            check_beat({tag, ".beat"}, base, k);
            tick();
            start = 1'b0;
        end
        check({tag, ".done"},       {31'd0, done},      32'd1);
        check({tag, ".done_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".done_busy"},  {31'd0, busy},      32'd1);
        start = poke_done;
        tick();
        start = 1'b0;
        check_idle({tag, ".idle"});
        tick();
        check_idle({tag, ".stay_idle"});
        mat_data = build(base);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        mat_data  = build(16'h0100);
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        stream("basic", 16'h0100, 16'h0000, 0, -1, 1'b0, 1'b0);
        stream("bp", 16'h0100, 16'h8081, 3, -1, 1'b0, 1'b0);
        stream("iso", 16'h0100, 16'h0000, 0, -1, 1'b0, 1'b1);
        stream("ign", 16'h0100, 16'h0000, 0, 4, 1'b1, 1'b0);

        // reset while beat 5 is on the bus
        mat_data = build(16'h0100);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) tick();
        check_beat("rst_pre", 16'h0100, 5);
        reset = 1'b1;
        tick();
        check_idle("rst_mid");
        reset = 1'b0;
        tick();
        check_idle("rst_after");

        stream("after_rst", 16'h0100, 16'h0000, 0, -1, 1'b0, 1'b0);
        stream("order", 16'h0000, 16'h0000, 0, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/output_serializer.md
Name: output_serializer

Overview:
- Sits directly downstream of the 256-bit output matrix register.
- On a start pulse, it reads the register through the register's read strobe and captures the 4x4 matrix of 16-bit elements.
- It then streams the 16 elements one per transfer over a valid/ready interface to the host/display/testbench port.
- Element (row r, col c) occupies bits [(r*4+c)*16 +: 16]; row0 col0 is bits 15:0.

Parameters:
- ELEM_W, 16, element width in bits
- DIM, 4, matrix dimension (DIM x DIM elements)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin one read-and-stream operation; sampled only in IDLE
- mat_read  output  1  read strobe to the output register (drives its read_data)
- mat_data  input  256  matrix bus from the output register (its data)
- out_data  output  16  current element
- out_index  output  4  linear index of the current element in stream order, 0..15
- out_valid  output  1  out_data/out_index are valid
- out_ready  input  1  consumer accepts the element when out_valid && out_ready at a clk edge
- out_last  output  1  high with out_valid on the final element (beat 15)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last element is accepted

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset is synchronous and active-high on port reset.
  - On reset: state=IDLE, beat counter=0, capture buffer=0.
  - Output reset values: mat_read=0, out_valid=0, out_last=0, out_data=0, out_index=0, busy=0, done=0.
- FSM states: IDLE, REQ, CAP, SEND, DONE.
- IDLE:
  - All outputs at their reset values.
  - start=1 at an edge -> REQ.
- REQ:
  - mat_read=1 for one cycle; the output register drives mat_data at the edge that ends REQ.
  - Always -> CAP.
- CAP:
  - mat_read held 1 so mat_data stays driven.
  - At the edge that ends CAP, the full 256-bit mat_data is latched into the internal buffer and the beat counter is set to 0.
  - -> SEND. mat_read returns to 0 from SEND onward; the register then releases the bus (z), which is don't-care.
- SEND:
  - out_valid=1.
  - out_data = buffer element selected by the beat counter; out_index = beat counter.
  - out_last = (beat==15).
  - On valid&&ready: beat increments. If beat==15 -> DONE instead.
  - With out_valid=1 and out_ready=0, out_data, out_index and out_last are held stable; no beat is lost.
- DONE:
  - done=1 for exactly one cycle, out_valid=0.
  - -> IDLE.
- Timing:
  - Latency: start sampled at edge E0. REQ in cycle 1, CAP in cycle 2, out_valid first high in cycle 3.
  - With out_ready tied high: 16 consecutive beats in cycles 3..18, done in cycle 19, IDLE in cycle 20.
- Default stream order: row-major. Beat k selects element k (row k/4, col k%4).
- Buffer isolation: the captured buffer is unaffected by later changes on mat_data; streaming always reflects the value sampled at the end of CAP.
- start while busy: ignored; no queuing.
- start in the same cycle as DONE: ignored; a new start must be seen in IDLE.
- Reset mid-operation (any state): IDLE at the next edge. All outputs take reset values, mat_read drops, no done pulse.
- Bit fidelity: z/x bits on mat_data at capture are latched as-is. Upstream guarantees driven data while mat_read=1.

Optional Feature:
- Macro: OUTPUT_SER_COL_MAJOR_EN.
- Defined: stream order is column-major. Beat k selects row k%4, col k/4, i.e. element index (k%4)*4 + k/4. out_index still reports beat k, not the element index.
- Undefined: row-major as above.
- Handshake, latency and out_last are identical in both builds.

Decomposition:
- Package output_ser_pkg holds:
  - ELEM_W=16, DIM=4, NUM_ELEM=16, BEAT_W=4
  - MAT_W=256
  - the state enumeration (IDLE, REQ, CAP, SEND, DONE)
- Sub-module ser_elem_select (natural split):
  - Combinational.
  - Inputs: 256-bit buffer and beat index. Output: the 16-bit element.
  - Contains the row/column-major index mapping under OUTPUT_SER_COL_MAJOR_EN.
- The top level holds the FSM, capture buffer and beat counter.

Test Plan:
- Basic stream: mat_data element i = 16'h0100+i, out_ready=1, start pulse. Required: mat_read high exactly in cycles 1-2; out_data 0100..010F in cycles 3..18; out_last only on 010F; done in cycle 19.
- Backpressure: same matrix, out_ready low for 3 cycles on beats 0, 7 and 15. Required: out_data/out_index held during stalls; all 16 values in order, none duplicated; done one cycle after beat 15 is accepted.
- Capture isolation: change mat_data to all 16'hFFFF in cycle 4. Required: the remaining beats still stream 0102..010F.
- Ignored start: pulse start during SEND and during DONE. Required: one stream only; busy stays high throughout; a start after return to IDLE launches a new full stream.
- Reset mid-stream: assert reset during beat 5. Required: next cycle out_valid=0, mat_read=0, busy=0, out_data=0, no done. A following start streams from beat 0.
- Column-major build (OUTPUT_SER_COL_MAJOR_EN defined), element i = i. Required: out_data sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15 with out_index 0..15.
